// File: rtl/cheshire_reg_ext_arbiter.sv
// Round-robin arbiter sharing the external register-bus slave port between NumReq requesters.
// A saturating per-transaction timeout turns a hung slave into an error response.
module cheshire_reg_ext_arbiter #(
    parameter int unsigned NumReq        = 4,
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 1024,
    parameter logic [DataWidth-1:0] ErrData = DataWidth'(32'hBADCAB1E),
    localparam int unsigned StrbWidth    = DataWidth / 8,
    localparam int unsigned IdxWidth     = $clog2(NumReq)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    input  logic [NumReq-1:0]             req_write_i,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
    input  logic [NumReq*StrbWidth-1:0]   req_wstrb_i,
    output logic [NumReq-1:0]             req_ready_o,
    output logic [DataWidth-1:0]          req_rdata_o,
    output logic                          req_error_o,
    output logic                          slv_valid_o,
    output logic                          slv_write_o,
    output logic [AddrWidth-1:0]          slv_addr_o,
    output logic [DataWidth-1:0]          slv_wdata_o,
    output logic [StrbWidth-1:0]          slv_wstrb_o,
    input  logic                          slv_ready_i,
    input  logic [DataWidth-1:0]          slv_rdata_i,
    input  logic                          slv_error_i,
    output logic [IdxWidth-1:0]           grant_idx_o,
    output logic                          busy_o,
    output logic                          timeout_o
);

    localparam int unsigned CntWidth = $clog2(TimeoutCycles) + 1;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_e;

    state_e                r_state;
    logic [IdxWidth-1:0]   r_grant;
    logic [IdxWidth-1:0]   r_rr_ptr;
    logic [CntWidth-1:0]   r_tmo_cnt;
    logic                  r_write;
    logic [AddrWidth-1:0]  r_addr;
    logic [DataWidth-1:0]  r_wdata;
    logic [StrbWidth-1:0]  r_wstrb;

    logic [IdxWidth-1:0]   w_pick;
    logic [IdxWidth-1:0]   w_pick_hi;
    logic [IdxWidth-1:0]   w_pick_lo;
    logic                  w_hit_hi;
    logic                  w_any_valid;
    logic [IdxWidth-1:0]   w_ptr_next;
    logic                  w_active;
    logic                  w_slv_done;
    logic                  w_tmo_hit;
    logic                  w_tmo_fire;
    logic                  w_complete;

    // Round-robin pick: lowest valid index at or above the pointer, else lowest valid overall.
    always_comb begin
        w_pick_hi = '0;
        w_pick_lo = '0;
        w_hit_hi  = 1'b0;
        for (int i = int'(NumReq) - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                w_pick_lo = IdxWidth'(i);
                if (IdxWidth'(i) >= r_rr_ptr) begin
                    w_pick_hi = IdxWidth'(i);
                    w_hit_hi  = 1'b1;
                end
            end
        end
        w_pick = w_hit_hi ? w_pick_hi : w_pick_lo;
    end

    assign w_any_valid = |req_valid_i;
    assign w_ptr_next  = (r_grant == IdxWidth'(NumReq - 1)) ? '0 : r_grant + IdxWidth'(1);

    assign w_active   = (r_state == ST_ACTIVE);
    assign w_slv_done = w_active && slv_ready_i;
    assign w_tmo_hit  = w_active && (r_tmo_cnt == CntWidth'(TimeoutCycles - 1));
    // A slave response in the timeout cycle takes priority over the error.
    assign w_tmo_fire = w_tmo_hit && !slv_ready_i;
    assign w_complete = w_slv_done || w_tmo_fire;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_tmo_cnt <= '0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_grant   <= w_pick;
                        r_write   <= req_write_i[w_pick];
                        r_addr    <= req_addr_i[w_pick*AddrWidth +: AddrWidth];
                        r_wdata   <= req_wdata_i[w_pick*DataWidth +: DataWidth];
                        r_wstrb   <= req_wstrb_i[w_pick*StrbWidth +: StrbWidth];
                        r_tmo_cnt <= '0;
                        r_state   <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_complete) begin
                        r_rr_ptr <= w_ptr_next;
                        r_state  <= ST_IDLE;
                    end else if (r_tmo_cnt != {CntWidth{1'b1}}) begin
                        r_tmo_cnt <= r_tmo_cnt + CntWidth'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            req_ready_o[i] = w_complete && (r_grant == IdxWidth'(i));
        end
    end

    assign req_rdata_o = w_slv_done ? slv_rdata_i : (w_tmo_fire ? ErrData : '0);
    assign req_error_o = w_slv_done ? slv_error_i : w_tmo_fire;
    assign timeout_o   = w_tmo_fire;

    assign slv_valid_o = w_active;
    assign busy_o      = w_active;
    assign slv_write_o = r_write;
    assign slv_addr_o  = r_addr;
    assign slv_wdata_o = r_wdata;
    assign slv_wstrb_o = r_wstrb;
    assign grant_idx_o = r_grant;

endmodule

// File: tb/tb_cheshire_reg_ext_arbiter.sv
// Directed bench for cheshire_reg_ext_arbiter; a scoreboard queue holds the expected
// response for each issued request and a monitor pops it on every completion pulse.
module tb_cheshire_reg_ext_arbiter;

    localparam int unsigned NumReq = 4;
    localparam int unsigned AW     = 48;
    localparam int unsigned DW     = 32;
    localparam int unsigned SW     = DW / 8;
    localparam int unsigned TMO    = 8;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [NumReq-1:0]    req_valid_i;
    logic [NumReq-1:0]    req_write_i;
    logic [NumReq*AW-1:0] req_addr_i;
    logic [NumReq*DW-1:0] req_wdata_i;
    logic [NumReq*SW-1:0] req_wstrb_i;
    logic [NumReq-1:0]    req_ready_o;
    logic [DW-1:0]        req_rdata_o;
    logic                 req_error_o;
    logic                 slv_valid_o;
    logic                 slv_write_o;
    logic [AW-1:0]        slv_addr_o;
    logic [DW-1:0]        slv_wdata_o;
    logic [SW-1:0]        slv_wstrb_o;
    logic                 slv_ready_i;
    logic [DW-1:0]        slv_rdata_i;
    logic                 slv_error_i;
    logic [1:0]           grant_idx_o;
    logic                 busy_o;
    logic                 timeout_o;

    cheshire_reg_ext_arbiter #(
        .NumReq       (NumReq),
        .AddrWidth    (AW),
        .DataWidth    (DW),
        .TimeoutCycles(TMO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_valid_i(req_valid_i),
        .req_write_i(req_write_i),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .req_wstrb_i(req_wstrb_i),
        .req_ready_o(req_ready_o),
        .req_rdata_o(req_rdata_o),
        .req_error_o(req_error_o),
        .slv_valid_o(slv_valid_o),
        .slv_write_o(slv_write_o),
        .slv_addr_o (slv_addr_o),
        .slv_wdata_o(slv_wdata_o),
        .slv_wstrb_o(slv_wstrb_o),
        .slv_ready_i(slv_ready_i),
        .slv_rdata_i(slv_rdata_i),
        .slv_error_i(slv_error_i),
        .grant_idx_o(grant_idx_o),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input int idx, input logic [31:0] rdata, input logic err, input logic tmo);
        exp_t e;
        e.idx   = idx;
        e.rdata = rdata;
        e.err   = err;
        e.tmo   = tmo;
        sb.push_back(e);
    endtask

    // Completion monitor: every req_ready_o pulse must match the oldest expected response.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i && req_ready_o != '0) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_ready", 64'(req_ready_o), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("sb_ready", 64'(req_ready_o), 64'(1) << e.idx);
                chk("sb_rdata", 64'(req_rdata_o), 64'(e.rdata));
                chk("sb_error", 64'(req_error_o), 64'(e.err));
                chk("sb_timeout", 64'(timeout_o), 64'(e.tmo));
            end
        end
    end

    initial begin
        int exp_order [5];
        int t;
        int prev;
        int b;
        exp_order = '{0, 1, 2, 3, 0};

        rst_i       = 1'b1;
        req_valid_i = '0;
        req_write_i = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_wstrb_i = '0;
        slv_ready_i = 1'b0;
        slv_rdata_i = '0;
        slv_error_i = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_slv_valid", 64'(slv_valid_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_grant", 64'(grant_idx_o), 64'(0));
        chk("rst_ready", 64'(req_ready_o), 64'(0));
        chk("rst_rdata", 64'(req_rdata_o), 64'(0));
        chk("rst_error", 64'(req_error_o), 64'(0));
        chk("rst_timeout", 64'(timeout_o), 64'(0));
        chk("rst_slv_addr", 64'(slv_addr_o), 64'(0));
        rst_i = 1'b0;
        tick();

        // Single write from requester 2, slave ready in the 4th ACTIVE cycle
        req_valid_i[2]          = 1'b1;
        req_write_i[2]          = 1'b1;
        req_addr_i[2*AW +: AW]  = 48'h0000_0300_0010;
        req_wdata_i[2*DW +: DW] = 32'h1234_5678;
        req_wstrb_i[2*SW +: SW] = 4'hF;
        slv_rdata_i             = 32'h0;
        push(2, 32'h0, 1'b0, 1'b0);
        chk("t1_idle_valid", 64'(slv_valid_o), 64'(0));
        tick();
        chk("t1_slv_valid", 64'(slv_valid_o), 64'(1));
        chk("t1_slv_write", 64'(slv_write_o), 64'(1));
        chk("t1_slv_addr", 64'(slv_addr_o), 64'h0300_0010);
        chk("t1_slv_wdata", 64'(slv_wdata_o), 64'h1234_5678);
        chk("t1_slv_wstrb", 64'(slv_wstrb_o), 64'hF);
        chk("t1_grant", 64'(grant_idx_o), 64'(2));
        chk("t1_busy", 64'(busy_o), 64'(1));
        tick();
        tick();
        chk("t1_no_early_ready", 64'(req_ready_o), 64'(0));
        tick();
        slv_ready_i = 1'b1;
        #1;
        chk("t1_ready", 64'(req_ready_o), 64'b0100);
        chk("t1_error", 64'(req_error_o), 64'(0));
        tick();
        req_valid_i = '0;
        slv_ready_i = 1'b0;
        chk("t1_back_idle", 64'(busy_o), 64'(0));
        tick();

        // Reset mid-transaction; pointer is 3 so requester 1 wins by wrapping
        req_valid_i[1] = 1'b1;
        req_write_i[1] = 1'b0;
        req_addr_i[1*AW +: AW] = 48'h0000_0300_0020;
        tick();
        chk("rm_grant_wrap", 64'(grant_idx_o), 64'(1));
        tick();
        rst_i = 1'b1;
        #1;
        chk("rm_slv_valid", 64'(slv_valid_o), 64'(0));
        chk("rm_busy", 64'(busy_o), 64'(0));
        chk("rm_grant", 64'(grant_idx_o), 64'(0));
        chk("rm_ready", 64'(req_ready_o), 64'(0));
        req_valid_i = '0;
        tick();
        rst_i = 1'b0;
        tick();
        req_valid_i[0] = 1'b1;
        req_valid_i[3] = 1'b1;
        slv_rdata_i    = 32'h1111_1111;
        push(0, 32'h1111_1111, 1'b0, 1'b0);
        push(3, 32'h1111_1111, 1'b0, 1'b0);
        tick();
        chk("rm_first_grant", 64'(grant_idx_o), 64'(0));
        slv_ready_i = 1'b1;
        tick();
        req_valid_i[0] = 1'b0;
        tick();
        chk("rm_second_grant", 64'(grant_idx_o), 64'(3));
        tick();
        req_valid_i = '0;
        slv_ready_i = 1'b0;
        tick();

        // Read pass-through from requester 1 with slave error
        req_valid_i[1] = 1'b1;
        req_write_i[1] = 1'b0;
        push(1, 32'hCAFE_F00D, 1'b1, 1'b0);
        tick();
        chk("rd_slv_write", 64'(slv_write_o), 64'(0));
        chk("rd_slv_addr", 64'(slv_addr_o), 64'h0300_0020);
        tick();
        slv_ready_i = 1'b1;
        slv_rdata_i = 32'hCAFE_F00D;
        slv_error_i = 1'b1;
        #1;
        chk("rd_ready", 64'(req_ready_o), 64'b0010);
        chk("rd_rdata", 64'(req_rdata_o), 64'hCAFE_F00D);
        chk("rd_error", 64'(req_error_o), 64'(1));
        tick();
        req_valid_i = '0;
        slv_ready_i = 1'b0;
        slv_error_i = 1'b0;
        tick();

        // Timeout: slave never ready; completion in ACTIVE cycle TMO
        req_valid_i[0] = 1'b1;
        slv_rdata_i    = 32'h0;
        push(0, 32'hBADC_AB1E, 1'b1, 1'b1);
        tick();
        for (int c = 1; c < int'(TMO); c++) begin
            if (c == int'(TMO) - 1) begin
                chk("to_cycle7_timeout", 64'(timeout_o), 64'(0));
                chk("to_cycle7_ready", 64'(req_ready_o), 64'(0));
            end
            tick();
        end
        chk("to_timeout", 64'(timeout_o), 64'(1));
        chk("to_ready", 64'(req_ready_o), 64'b0001);
        chk("to_error", 64'(req_error_o), 64'(1));
        chk("to_rdata", 64'(req_rdata_o), 64'hBADC_AB1E);
        tick();
        req_valid_i = '0;
        chk("to_idle_busy", 64'(busy_o), 64'(0));
        chk("to_idle_valid", 64'(slv_valid_o), 64'(0));
        slv_ready_i = 1'b1;
        slv_rdata_i = 32'hDEAD_0001;
        #1;
        chk("to_late_ready", 64'(req_ready_o), 64'(0));
        chk("to_late_timeout", 64'(timeout_o), 64'(0));
        tick();
        slv_ready_i = 1'b0;
        tick();

        // Slave ready exactly on the timeout cycle: normal completion wins
        req_valid_i[1] = 1'b1;
        push(1, 32'h5A5A_0001, 1'b0, 1'b0);
        tick();
        for (int c = 1; c < int'(TMO); c++) tick();
        slv_ready_i = 1'b1;
        slv_rdata_i = 32'h5A5A_0001;
        #1;
        chk("rt_timeout", 64'(timeout_o), 64'(0));
        chk("rt_ready", 64'(req_ready_o), 64'b0010);
        chk("rt_rdata", 64'(req_rdata_o), 64'h5A5A_0001);
        chk("rt_error", 64'(req_error_o), 64'(0));
        tick();
        req_valid_i = '0;
        slv_ready_i = 1'b0;
        tick();

        // Round robin from a fresh pointer: all requesters valid, slave always ready
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        slv_ready_i = 1'b1;
        slv_rdata_i = 32'h0000_0077;
        for (int k = 0; k < 5; k++) push(exp_order[k], 32'h0000_0077, 1'b0, 1'b0);
        req_valid_i = '1;
        t    = 0;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            b = 0;
            do begin
                tick();
                t++;
                b++;
            end while (req_ready_o == '0 && b < 20);
            chk("rr_order", 64'(req_ready_o), 64'(1) << exp_order[k]);
            if (k > 0) chk("rr_spacing", 64'(t - prev), 64'(2));
            prev = t;
        end
        tick();
        req_valid_i = '0;
        slv_ready_i = 1'b0;
        tick();
        tick();

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
